// File: rtl/gb_bus_pkg.sv
// Shared state/region types, MBC register selects and the CPU address map for gb_bus_ctrl.
package gb_bus_pkg;

   typedef enum logic [1:0] {StIdle, StCart, StWram, StDone} state_e;

   typedef enum logic [2:0] {RegNone, RegRom, RegCartRam, RegWram, RegSvbk} region_e;

   // MBC register select is taken straight from cpu_addr[14:13] of a ROM-range write.
   typedef enum logic [1:0] {MbcRamEn, MbcRomBank, MbcRamBank, MbcMode} mbc_sel_e;

   localparam logic [15:0] RomBase      = 16'h0000;
   localparam logic [15:0] RomLimit     = 16'h7FFF;
   localparam logic [15:0] CartRamBase  = 16'hA000;
   localparam logic [15:0] CartRamLimit = 16'hBFFF;
   localparam logic [15:0] WramBase     = 16'hC000;
   localparam logic [15:0] WramLimit    = 16'hDFFF;
   localparam logic [15:0] EchoBase     = 16'hE000;
   localparam logic [15:0] EchoLimit    = 16'hFDFF;
   localparam logic [15:0] SvbkAddr     = 16'hFF70;
   localparam logic [3:0]  RamEnKey     = 4'hA;

   function automatic region_e decode_region(input logic [15:0] addr, input logic svbk_en);
      region_e region;
      region = RegNone;
      if (addr <= RomLimit) begin
         region = RegRom;
      end else if (addr >= CartRamBase && addr <= CartRamLimit) begin
         region = RegCartRam;
      end else if ((addr >= WramBase && addr <= WramLimit) ||
                   (addr >= EchoBase && addr <= EchoLimit)) begin
         region = RegWram;
      end else if (svbk_en && addr == SvbkAddr) begin
         region = RegSvbk;
      end
      return region;
   endfunction

endpackage

// File: rtl/gb_mbc_regs.sv
// MBC bank/enable/mode registers plus the CGB WRAM bank register.
// WRAM banking is writable only when GB_BUS_CGB_WRAM_EN is defined; otherwise bank 1 is fixed.
module gb_mbc_regs
   import gb_bus_pkg::*;
#(
   parameter int unsigned ROM_BANK_BITS  = 7,
   parameter int unsigned RAM_BANK_BITS  = 2,
   parameter int unsigned WRAM_BANK_BITS = 3
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      mbc_we_i,
   input  mbc_sel_e                  mbc_sel_i,
   input  logic                      svbk_we_i,
   input  logic [7:0]                din_i,
   output logic [ROM_BANK_BITS-1:0]  rom_bank_o,
   output logic [RAM_BANK_BITS-1:0]  ram_bank_o,
   output logic                      ram_en_o,
   output logic                      mode_o,
   output logic [WRAM_BANK_BITS-1:0] wram_bank_o
);

   logic [ROM_BANK_BITS-1:0] rom_bank_q, rom_trunc, rom_bank_d;
   logic [RAM_BANK_BITS-1:0] ram_bank_q;
   logic                     ram_en_q, mode_q;

   // Zero check happens on the truncated value, so e.g. 0x80 with 7 bits also becomes bank 1.
   assign rom_trunc  = din_i[ROM_BANK_BITS-1:0];
   assign rom_bank_d = (rom_trunc == '0) ? ROM_BANK_BITS'(1) : rom_trunc;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rom_bank_q <= ROM_BANK_BITS'(1);
         ram_bank_q <= '0;
         ram_en_q   <= 1'b0;
         mode_q     <= 1'b0;
      end else if (mbc_we_i) begin
         case (mbc_sel_i)
            MbcRamEn:   ram_en_q   <= (din_i[3:0] == RamEnKey);
            MbcRomBank: rom_bank_q <= rom_bank_d;
            MbcRamBank: ram_bank_q <= din_i[RAM_BANK_BITS-1:0];
            MbcMode:    mode_q     <= din_i[0];
            default:    mode_q     <= mode_q;
         endcase
      end
   end

   assign rom_bank_o = rom_bank_q;
   assign ram_bank_o = ram_bank_q;
   assign ram_en_o   = ram_en_q;
   assign mode_o     = mode_q;

`ifdef GB_BUS_CGB_WRAM_EN
   logic [WRAM_BANK_BITS-1:0] wram_bank_q, wram_trunc, wram_bank_d;

   assign wram_trunc  = din_i[WRAM_BANK_BITS-1:0];
   assign wram_bank_d = (wram_trunc == '0) ? WRAM_BANK_BITS'(1) : wram_trunc;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wram_bank_q <= WRAM_BANK_BITS'(1);
      end else if (svbk_we_i) begin
         wram_bank_q <= wram_bank_d;
      end
   end

   assign wram_bank_o = wram_bank_q;
`else
   logic unused_svbk;
   assign unused_svbk = svbk_we_i;
   assign wram_bank_o = WRAM_BANK_BITS'(1);
`endif

   logic unused_din;
   assign unused_din = ^din_i;

endmodule

// File: rtl/gb_bus_ctrl.sv
// Game Boy CPU bus controller: region decode, MBC banking, cartridge strobes and WRAM access.
// Define GB_BUS_CGB_WRAM_EN to enable the CGB SVBK (FF70) WRAM bank register.
module gb_bus_ctrl
   import gb_bus_pkg::*;
#(
   parameter int unsigned ROM_BANK_BITS  = 7,
   parameter int unsigned RAM_BANK_BITS  = 2,
   parameter int unsigned WRAM_BANK_BITS = 3,
   parameter int unsigned CART_WAIT      = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [15:0]                  cpu_addr,
   input  logic [7:0]                   cpu_din,
   input  logic                         cpu_rd,
   input  logic                         cpu_wr,
   output logic [7:0]                   cpu_dout,
   output logic                         cpu_ready,
   output logic [14+ROM_BANK_BITS-1:0]  cart_rom_addr,
   output logic [13+RAM_BANK_BITS-1:0]  cart_ram_addr,
   output logic                         cart_rd,
   output logic                         cart_wr,
   input  logic [7:0]                   cart_din,
   output logic [7:0]                   cart_dout,
   output logic [12+WRAM_BANK_BITS-1:0] wram_addr,
   output logic                         wram_we,
   output logic [7:0]                   wram_wdata,
   input  logic [7:0]                   wram_rdata
);

`ifdef GB_BUS_CGB_WRAM_EN
   localparam logic SvbkEn = 1'b1;
`else
   localparam logic SvbkEn = 1'b0;
`endif

   state_e      state_q;
   logic        rd_prev_q, wr_prev_q;
   logic [15:0] addr_q;
   logic [7:0]  din_q, dout_q;
   logic        write_q, ready_q, cart_rd_q, cart_wr_q, wram_we_q;
   logic [3:0]  cnt_q;

   logic                      rd_rise, wr_rise, rise_any, cart_go;
   region_e                   start_region;
   logic                      mbc_we, svbk_we;
   logic [ROM_BANK_BITS-1:0]  rom_bank, rom_bank_eff;
   logic [RAM_BANK_BITS-1:0]  ram_bank, ram_bank_eff;
   logic                      ram_en, mode;
   logic [WRAM_BANK_BITS-1:0] wram_bank;
   logic [15:0]               wram_src;
   logic [7:0]                svbk_rdata;

   // A simultaneous rd/wr edge counts as a write.
   assign rd_rise      = cpu_rd & ~rd_prev_q;
   assign wr_rise      = cpu_wr & ~wr_prev_q;
   assign rise_any     = rd_rise | wr_rise;
   assign start_region = decode_region(cpu_addr, SvbkEn);

   assign mbc_we  = (state_q == StIdle) & wr_rise & (start_region == RegRom);
   assign svbk_we = (state_q == StIdle) & wr_rise & (start_region == RegSvbk);
   assign cart_go = ((start_region == RegRom) & ~wr_rise) |
                    ((start_region == RegCartRam) & ram_en);

   gb_mbc_regs #(
      .ROM_BANK_BITS  (ROM_BANK_BITS),
      .RAM_BANK_BITS  (RAM_BANK_BITS),
      .WRAM_BANK_BITS (WRAM_BANK_BITS)
   ) u_mbc_regs (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .mbc_we_i    (mbc_we),
      .mbc_sel_i   (mbc_sel_e'(cpu_addr[14:13])),
      .svbk_we_i   (svbk_we),
      .din_i       (cpu_din),
      .rom_bank_o  (rom_bank),
      .ram_bank_o  (ram_bank),
      .ram_en_o    (ram_en),
      .mode_o      (mode),
      .wram_bank_o (wram_bank)
   );

   always_comb begin
      rom_bank_eff = '0;
      if (addr_q[14]) begin
         rom_bank_eff = rom_bank;
      end else if (mode && ROM_BANK_BITS > 5) begin
         rom_bank_eff = ROM_BANK_BITS'({ram_bank, 5'b0});
      end
   end

   assign ram_bank_eff  = mode ? ram_bank : '0;
   assign cart_rom_addr = {rom_bank_eff, addr_q[13:0]};
   assign cart_ram_addr = {ram_bank_eff, addr_q[12:0]};

   // The address goes to the sync RAM during the start cycle so read data is ready in StWram.
   // Echo (addr - 0x2000) only touches bits 13+, so the low 13 bits select the WRAM byte as is.
   assign wram_src  = (state_q == StIdle) ? cpu_addr : addr_q;
   assign wram_addr = {wram_src[12] ? wram_bank : WRAM_BANK_BITS'(0), wram_src[11:0]};

   always_comb begin
      svbk_rdata                       = 8'hFF;
      svbk_rdata[WRAM_BANK_BITS-1:0]   = wram_bank;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         rd_prev_q <= 1'b0;
         wr_prev_q <= 1'b0;
         addr_q    <= '0;
         din_q     <= '0;
         write_q   <= 1'b0;
         cnt_q     <= '0;
         dout_q    <= 8'hFF;
         ready_q   <= 1'b0;
         cart_rd_q <= 1'b0;
         cart_wr_q <= 1'b0;
         wram_we_q <= 1'b0;
      end else begin
         rd_prev_q <= cpu_rd;
         wr_prev_q <= cpu_wr;
         ready_q   <= 1'b0;
         wram_we_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (rise_any) begin
                  addr_q  <= cpu_addr;
                  din_q   <= cpu_din;
                  write_q <= wr_rise;
                  if (start_region == RegWram) begin
                     state_q   <= StWram;
                     wram_we_q <= wr_rise;
                  end else if (cart_go) begin
                     state_q   <= StCart;
                     cnt_q     <= 4'(CART_WAIT - 1);
                     cart_rd_q <= ~wr_rise;
                     cart_wr_q <= wr_rise;
                  end else begin
                     // MBC writes, disabled cart RAM, SVBK and unclaimed addresses finish here.
                     state_q <= StDone;
                     ready_q <= 1'b1;
                     if (!wr_rise) begin
                        dout_q <= (start_region == RegSvbk) ? svbk_rdata : 8'hFF;
                     end
                  end
               end
            end
            StCart: begin
               if (cnt_q == '0) begin
                  state_q   <= StDone;
                  ready_q   <= 1'b1;
                  cart_rd_q <= 1'b0;
                  cart_wr_q <= 1'b0;
                  if (!write_q) begin
                     dout_q <= cart_din;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StWram: begin
               state_q <= StDone;
               ready_q <= 1'b1;
               if (!write_q) begin
                  dout_q <= wram_rdata;
               end
            end
            StDone: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign cpu_dout   = dout_q;
   assign cpu_ready  = ready_q;
   assign cart_rd    = cart_rd_q;
   assign cart_wr    = cart_wr_q;
   assign cart_dout  = din_q;
   assign wram_we    = wram_we_q;
   assign wram_wdata = din_q;

   logic unused_addr;
   assign unused_addr = addr_q[15];

endmodule

// File: tb/tb_gb_bus_ctrl.sv
// Scoreboard bench for gb_bus_ctrl: directed accesses push expectations, a monitor checks them.
module tb_gb_bus_ctrl;
   import gb_bus_pkg::*;

   localparam int CW = 2;

   typedef struct {
      string       name;
      logic [7:0]  dout;
      int          lat;
      int          rd;
      int          wr;
      int          we;
      int          sel;
      logic [31:0] addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_din = '0;
   logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
   logic [7:0]  cpu_dout;
   logic        cpu_ready;
   logic [20:0] cart_rom_addr;
   logic [14:0] cart_ram_addr;
   logic        cart_rd, cart_wr;
   logic [7:0]  cart_din, cart_dout;
   logic [14:0] wram_addr;
   logic        wram_we;
   logic [7:0]  wram_wdata, wram_rdata;

   logic [7:0]  cart_data = 8'h00;
   int          rd_cnt = 0;
   logic [7:0]  mem [0:32767];

   int   checks = 0;
   int   fails = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   gb_bus_ctrl #(
      .CART_WAIT (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cpu_addr      (cpu_addr),
      .cpu_din       (cpu_din),
      .cpu_rd        (cpu_rd),
      .cpu_wr        (cpu_wr),
      .cpu_dout      (cpu_dout),
      .cpu_ready     (cpu_ready),
      .cart_rom_addr (cart_rom_addr),
      .cart_ram_addr (cart_ram_addr),
      .cart_rd       (cart_rd),
      .cart_wr       (cart_wr),
      .cart_din      (cart_din),
      .cart_dout     (cart_dout),
      .wram_addr     (wram_addr),
      .wram_we       (wram_we),
      .wram_wdata    (wram_wdata),
      .wram_rdata    (wram_rdata)
   );

   // Cartridge returns valid data only in the last strobe cycle.
   always @(posedge clk) rd_cnt <= cart_rd ? rd_cnt + 1 : 0;
   assign cart_din = (rd_cnt == CW - 1) ? cart_data : 8'hEE;

   initial for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
   always @(posedge clk) begin
      if (wram_we) mem[wram_addr] <= wram_wdata;
      wram_rdata <= mem[wram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input string n, input logic [7:0] d, input int lat, input int rd,
                               input int wr, input int we, input int sel, input logic [31:0] a);
      exp_t e;
      e.name = n; e.dout = d; e.lat = lat; e.rd = rd; e.wr = wr; e.we = we; e.sel = sel;
      e.addr = a;
      return e;
   endfunction

   task automatic access(input bit rd_en, input bit wr_en, input logic [15:0] a,
                         input logic [7:0] d, input exp_t e);
      int n;
      sb.push_back(e);
      @(negedge clk);
      cpu_addr = a;
      cpu_din  = d;
      cpu_rd   = rd_en;
      cpu_wr   = wr_en;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cpu_ready && n < 40);
      if (!cpu_ready) begin
         checks++;
         fails++;
         $display("FAIL %s_timeout: no cpu_ready after %0d cycles", e.name, n);
         void'(sb.pop_back());
      end else begin
         chk({e.name, "_lat"}, n, e.lat);
      end
      cpu_rd = 1'b0;
      cpu_wr = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      exp_t        e;
      int          rd_cyc, wr_cyc, we_cyc;
      logic [31:0] cap_rom, cap_ram, cap_wram;
      logic        prev_ready;
      rd_cyc = 0; wr_cyc = 0; we_cyc = 0; prev_ready = 1'b0;
      cap_rom = 32'hDEADBEEF; cap_ram = 32'hDEADBEEF; cap_wram = 32'hDEADBEEF;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            rd_cyc = 0; wr_cyc = 0; we_cyc = 0; prev_ready = 1'b0;
         end else begin
            if (cart_rd) rd_cyc++;
            if (cart_wr) wr_cyc++;
            if (cart_rd || cart_wr) begin
               cap_rom = 32'(cart_rom_addr);
               cap_ram = 32'(cart_ram_addr);
            end
            if (wram_we) begin
               we_cyc++;
               cap_wram = 32'(wram_addr);
            end
            if (cpu_ready) begin
               chk("ready_single_cycle", 32'(prev_ready), 0);
               if (sb.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL spurious_ready: got a cpu_ready pulse, expected none");
               end else begin
                  e = sb.pop_front();
                  chk({e.name, "_dout"}, 32'(cpu_dout), 32'(e.dout));
                  chk({e.name, "_cart_rd_cycles"}, rd_cyc, e.rd);
                  chk({e.name, "_cart_wr_cycles"}, wr_cyc, e.wr);
                  chk({e.name, "_wram_we_cycles"}, we_cyc, e.we);
                  if (e.sel == 1) chk({e.name, "_rom_addr"}, cap_rom, e.addr);
                  if (e.sel == 2) chk({e.name, "_ram_addr"}, cap_ram, e.addr);
                  if (e.sel == 3) chk({e.name, "_wram_addr"}, cap_wram, e.addr);
               end
               rd_cyc = 0; wr_cyc = 0; we_cyc = 0;
               cap_rom = 32'hDEADBEEF; cap_ram = 32'hDEADBEEF; cap_wram = 32'hDEADBEEF;
            end
            prev_ready = cpu_ready;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d010_addr;
      logic [7:0]  svbk_rd, svbk_rst;
`ifdef GB_BUS_CGB_WRAM_EN
      d010_addr = 32'h3010; svbk_rd = 8'hFB; svbk_rst = 8'hF9;
`else
      d010_addr = 32'h1010; svbk_rd = 8'hFF; svbk_rst = 8'hFF;
`endif
      repeat (3) @(negedge clk);
      chk("reset_dout", 32'(cpu_dout), 32'hFF);
      chk("reset_ready", 32'(cpu_ready), 0);
      chk("reset_strobes", {29'd0, cart_rd, cart_wr, wram_we}, 0);
      rst_n = 1'b1;

      access(0, 1, 16'h2000, 8'h00, mk("mbc_rom0", 8'hFF, 1, 0, 0, 0, 0, 0));
      cart_data = 8'h11;
      access(1, 0, 16'h4000, 8'h00, mk("rom_bank1", 8'h11, CW+1, CW, 0, 0, 1, 32'h04000));
      access(0, 1, 16'h2000, 8'h85, mk("mbc_rom85", 8'h11, 1, 0, 0, 0, 0, 0));
      cart_data = 8'h22;
      access(1, 0, 16'h4123, 8'h00, mk("rom_bank5", 8'h22, CW+1, CW, 0, 0, 1, 32'h14123));
      cart_data = 8'h33;
      access(1, 0, 16'h1234, 8'h00, mk("rom_bank0", 8'h33, CW+1, CW, 0, 0, 1, 32'h01234));
      access(1, 0, 16'hA000, 8'h00, mk("ram_off_rd", 8'hFF, 1, 0, 0, 0, 0, 0));
      access(0, 1, 16'h0000, 8'h0A, mk("ram_en", 8'hFF, 1, 0, 0, 0, 0, 0));
      access(0, 1, 16'h4000, 8'h03, mk("ram_bank3", 8'hFF, 1, 0, 0, 0, 0, 0));
      cart_data = 8'h44;
      access(1, 0, 16'hA123, 8'h00, mk("ram_mode0", 8'h44, CW+1, CW, 0, 0, 2, 32'h00123));
      access(0, 1, 16'h6000, 8'h01, mk("mode1", 8'h44, 1, 0, 0, 0, 0, 0));
      cart_data = 8'h55;
      access(1, 0, 16'hB456, 8'h00, mk("ram_mode1", 8'h55, CW+1, CW, 0, 0, 2, 32'h07456));
      cart_data = 8'h66;
      access(1, 0, 16'h0010, 8'h00, mk("rom_mode1", 8'h66, CW+1, CW, 0, 0, 1, 32'h180010));
      access(0, 1, 16'hA010, 8'h77, mk("ram_wr", 8'h66, CW+1, 0, CW, 0, 2, 32'h06010));
      access(0, 1, 16'h0000, 8'h1B, mk("ram_dis", 8'h66, 1, 0, 0, 0, 0, 0));
      access(0, 1, 16'hA000, 8'h99, mk("ram_off_wr", 8'h66, 1, 0, 0, 0, 0, 0));
      access(0, 1, 16'h6000, 8'h00, mk("mode0", 8'h66, 1, 0, 0, 0, 0, 0));
      access(0, 1, 16'hFF70, 8'h03, mk("svbk_wr", 8'h66, 1, 0, 0, 0, 0, 0));
      access(0, 1, 16'hD010, 8'h5A, mk("wram_bank_wr", 8'h66, 2, 0, 0, 1, 3, d010_addr));
      access(1, 0, 16'hF010, 8'h00, mk("echo_rd", 8'h5A, 2, 0, 0, 0, 0, 0));
      access(1, 0, 16'hFF70, 8'h00, mk("svbk_rd", svbk_rd, 1, 0, 0, 0, 0, 0));
      access(0, 1, 16'hC005, 8'hC3, mk("wram0_wr", svbk_rd, 2, 0, 0, 1, 3, 32'h00005));
      access(1, 0, 16'hE005, 8'h00, mk("echo0_rd", 8'hC3, 2, 0, 0, 0, 0, 0));
      access(1, 1, 16'hC000, 8'h3C, mk("rd_wr_same", 8'hC3, 2, 0, 0, 1, 3, 32'h00000));
      access(1, 0, 16'hC000, 8'h00, mk("wram_rd", 8'h3C, 2, 0, 0, 0, 0, 0));
      access(1, 0, 16'h8000, 8'h00, mk("unclaimed", 8'hFF, 1, 0, 0, 0, 0, 0));
      access(1, 0, 16'hFF80, 8'h00, mk("unclaimed_hi", 8'hFF, 1, 0, 0, 0, 0, 0));
      access(0, 1, 16'h2000, 8'h80, mk("mbc_trunc0", 8'hFF, 1, 0, 0, 0, 0, 0));
      cart_data = 8'h77;
      access(1, 0, 16'h4000, 8'h00, mk("rom_trunc0", 8'h77, CW+1, CW, 0, 0, 1, 32'h04000));

      // Dirty every register, then reset in the middle of a cartridge read.
      access(0, 1, 16'h2000, 8'h07, mk("pre_rom7", 8'h77, 1, 0, 0, 0, 0, 0));
      access(0, 1, 16'h0000, 8'h0A, mk("pre_ram_en", 8'h77, 1, 0, 0, 0, 0, 0));
      access(0, 1, 16'h4000, 8'h02, mk("pre_ram_bank", 8'h77, 1, 0, 0, 0, 0, 0));
      access(0, 1, 16'h6000, 8'h01, mk("pre_mode1", 8'h77, 1, 0, 0, 0, 0, 0));
      access(0, 1, 16'hFF70, 8'h02, mk("pre_svbk", 8'h77, 1, 0, 0, 0, 0, 0));
      @(negedge clk);
      cpu_addr = 16'h4000;
      cpu_rd = 1'b1;
      @(negedge clk);
      chk("abort_cart_rd_active", 32'(cart_rd), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_cart_rd_async", 32'(cart_rd), 0);
      chk("abort_ready", 32'(cpu_ready), 0);
      chk("abort_dout", 32'(cpu_dout), 32'hFF);
      cpu_rd = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_ready_held", 32'(cpu_ready), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      cart_data = 8'h12;
      access(1, 0, 16'h4000, 8'h00, mk("post_rom_bank", 8'h12, CW+1, CW, 0, 0, 1, 32'h04000));
      access(1, 0, 16'hA000, 8'h00, mk("post_ram_en", 8'hFF, 1, 0, 0, 0, 0, 0));
      cart_data = 8'h34;
      access(1, 0, 16'h0010, 8'h00, mk("post_mode", 8'h34, CW+1, CW, 0, 0, 1, 32'h00010));
      access(1, 0, 16'hFF70, 8'h00, mk("post_svbk", svbk_rst, 1, 0, 0, 0, 0, 0));

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
